// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: the hazard-unit stage command and helpers.
package pipeline_pkg;

  localparam int unsigned PIPE_CTRL_W = 2;

  // Stage command driven by the hazard unit to every pipe_stage.
  typedef enum logic [PIPE_CTRL_W-1:0] {
    CONTINUE = 2'd0,
    STALL    = 2'd1,
    FLUSH    = 2'd2,
    BUBBLE   = 2'd3
  } pipeline_control_t;

endpackage : pipeline_pkg

// File: rtl/pipe_stage_sat_counter.sv
// Saturating up-counter used for stage performance statistics.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, clears the count
//   inc_i   : add one this cycle unless already at all-ones
//   count_o : current count
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Stick at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : sat_counter

// File: rtl/pipe_stage.sv
// Generic pipeline stage register with valid/ready handshake, hazard-unit
// command (CONTINUE/STALL/FLUSH/BUBBLE), optional one-entry skid buffer and
// saturating stall/flush cycle counters.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   pipeline_control_i  : stage command
//   up_valid_i/up_data_i/up_ready_o : upstream handshake
//   dn_valid_o/dn_data_o/dn_ready_i : downstream handshake
//   stall_count_o/flush_count_o     : saturating STALL / FLUSH cycle counts
module pipe_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0,
  parameter int unsigned     SKID        = 0,
  parameter int unsigned     CNT_WIDTH   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  pipeline_control_t    pipeline_control_i,
  input  logic                 up_valid_i,
  input  logic [WIDTH-1:0]     up_data_i,
  output logic                 up_ready_o,
  output logic                 dn_valid_o,
  output logic [WIDTH-1:0]     dn_data_o,
  input  logic                 dn_ready_i,
  output logic [CNT_WIDTH-1:0] stall_count_o,
  output logic [CNT_WIDTH-1:0] flush_count_o
);

  logic             is_cont;
  logic             is_stall;
  logic             is_flush;
  logic             is_bubble;
  logic             out_valid_q;
  logic             out_valid_d;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  logic             skid_full;
  logic             up_xfer;
  logic             dn_xfer;

  // Command decode; any unrecognised encoding is treated as STALL.
  always_comb begin
    is_cont   = 1'b0;
    is_stall  = 1'b0;
    is_flush  = 1'b0;
    is_bubble = 1'b0;
    case (pipeline_control_i)
      CONTINUE: is_cont   = 1'b1;
      STALL:    is_stall  = 1'b1;
      FLUSH:    is_flush  = 1'b1;
      BUBBLE:   is_bubble = 1'b1;
      default:  is_stall  = 1'b1;
    endcase
  end

  // Ready: with the skid buffer it no longer looks at dn_ready_i.
  always_comb begin
    up_ready_o = 1'b0;
    if (!rst_i && is_cont) begin
      if (SKID != 0) begin
        up_ready_o = !skid_full;
      end else begin
        up_ready_o = !out_valid_q || dn_ready_i;
      end
    end
  end

  assign dn_valid_o = out_valid_q && !is_stall;
  assign dn_data_o  = out_data_q;
  assign up_xfer    = up_valid_i && up_ready_o;
  assign dn_xfer    = dn_valid_o && dn_ready_i;

  if (SKID != 0) begin : g_skid
    logic             skid_valid_q;
    logic             skid_valid_d;
    logic [WIDTH-1:0] skid_data_q;
    logic [WIDTH-1:0] skid_data_d;

    // Output slot refills from the skid first so ordering is preserved;
    // BUBBLE only drains, it never accepts new upstream data.
    always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (is_flush) begin
        out_valid_d  = 1'b0;
        out_data_d   = FLUSH_VALUE;
        skid_valid_d = 1'b0;
        skid_data_d  = FLUSH_VALUE;
      end else if (is_cont || is_bubble) begin
        if (!out_valid_q || dn_xfer) begin
          if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
            skid_data_d  = FLUSH_VALUE;
          end else if (up_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = up_data_i;
          end else begin
            out_valid_d = 1'b0;
            out_data_d  = FLUSH_VALUE;
          end
        end else if (up_xfer) begin
          skid_valid_d = 1'b1;
          skid_data_d  = up_data_i;
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        skid_valid_q <= 1'b0;
        skid_data_q  <= FLUSH_VALUE;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_data_q  <= skid_data_d;
      end
    end

    assign skid_full = skid_valid_q;
  end else begin : g_no_skid
    // Single register: a load cycle is any CONTINUE cycle with ready high.
    always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (is_flush) begin
        out_valid_d = 1'b0;
        out_data_d  = FLUSH_VALUE;
      end else if (is_bubble) begin
        if (!out_valid_q || dn_xfer) begin
          out_valid_d = 1'b0;
          out_data_d  = FLUSH_VALUE;
        end
      end else if (is_cont && up_ready_o) begin
        out_valid_d = up_valid_i;
        out_data_d  = up_valid_i ? up_data_i : FLUSH_VALUE;
      end
    end

    assign skid_full = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= FLUSH_VALUE;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Flag X/Z commands in simulation; hardware falls back to STALL.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!$isunknown(pipeline_control_i))
        else $error("pipe_stage: unknown pipeline_control_i encoding");
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (is_stall),
    .count_o (stall_count_o)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (is_flush),
    .count_o (flush_count_o)
  );

endmodule : pipe_stage

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: one SKID=0 and one SKID=1 instance, directed checks
// plus a per-instance ordering scoreboard.
module tb_pipe_stage;
  import pipeline_pkg::*;

  localparam logic [7:0] FV0 = 8'hE0;
  localparam logic [7:0] FV1 = 8'h5A;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipeline_control_t ctl0 = CONTINUE, ctl1 = CONTINUE;
  logic       uv0 = 1'b0, uv1 = 1'b0;
  logic [7:0] ud0 = '0,   ud1 = '0;
  logic       dr0 = 1'b1, dr1 = 1'b1;
  logic       ur0, ur1, dv0, dv1;
  logic [7:0] dd0, dd1;
  logic [3:0] sc0, sc1, fc0, fc1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  always #5 clk = ~clk;

  pipe_stage #(.WIDTH(8), .FLUSH_VALUE(FV0), .SKID(0), .CNT_WIDTH(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .pipeline_control_i(ctl0),
    .up_valid_i(uv0), .up_data_i(ud0), .up_ready_o(ur0),
    .dn_valid_o(dv0), .dn_data_o(dd0), .dn_ready_i(dr0),
    .stall_count_o(sc0), .flush_count_o(fc0)
  );

  pipe_stage #(.WIDTH(8), .FLUSH_VALUE(FV1), .SKID(1), .CNT_WIDTH(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .pipeline_control_i(ctl1),
    .up_valid_i(uv1), .up_data_i(ud1), .up_ready_o(ur1),
    .dn_valid_o(dv1), .dn_data_o(dd1), .dn_ready_i(dr1),
    .stall_count_o(sc1), .flush_count_o(fc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: transfers complete at the next posedge, so sample at negedge.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (dv0 && dr0) begin
        if (q0.size() == 0) check("sb0_extra", 32'(q0.size()), 32'd1);
        else check("sb0_data", 32'(dd0), 32'(q0.pop_front()));
      end
      if (dv1 && dr1) begin
        if (q1.size() == 0) check("sb1_extra", 32'(q1.size()), 32'd1);
        else check("sb1_data", 32'(dd1), 32'(q1.pop_front()));
      end
      if (ctl0 == STALL) check("stall0_dv", 32'(dv0), 32'd0);
      if (ctl1 == STALL) check("stall1_dv", 32'(dv1), 32'd0);
      if (ctl0 == FLUSH) q0.delete();
      else if (uv0 && ur0) q0.push_back(ud0);
      if (ctl1 == FLUSH) q1.delete();
      else if (uv1 && ur1) q1.push_back(ud1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq [3];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dv0", 32'(dv0), 32'd0);
    check("rst_dd0", 32'(dd0), 32'(FV0));
    check("rst_ur0", 32'(ur0), 32'd0);
    check("rst_dv1", 32'(dv1), 32'd0);
    check("rst_dd1", 32'(dd1), 32'(FV1));
    check("rst_sc1", 32'(sc1), 32'd0);
    check("rst_fc1", 32'(fc1), 32'd0);
    tick(); rst = 1'b0;

    // Basic flow, SKID=0
    for (int i = 0; i < 3; i++) begin
      tick(); uv0 = 1'b1; ud0 = seq[i];
      @(negedge clk);
      check("flow_ur0", 32'(ur0), 32'd1);
      if (i > 0) begin
        check("flow_dd0", 32'(dd0), 32'(seq[i-1]));
        check("flow_dv0", 32'(dv0), 32'd1);
      end
    end
    tick(); uv0 = 1'b0;
    @(negedge clk);
    check("flow_dd0_last", 32'(dd0), 32'h33);
    check("flow_dv0_last", 32'(dv0), 32'd1);
    tick();
    @(negedge clk);
    check("flow_empty_dv0", 32'(dv0), 32'd0);
    check("flow_empty_dd0", 32'(dd0), 32'(FV0));

    // Backpressure, SKID=1
    tick(); dr1 = 1'b0; uv1 = 1'b1; ud1 = 8'hA1;
    @(negedge clk); check("bp_ur1_a", 32'(ur1), 32'd1);
    tick(); ud1 = 8'hA2;
    @(negedge clk);
    check("bp_dd1_a1", 32'(dd1), 32'hA1);
    check("bp_ur1_b", 32'(ur1), 32'd1);
    tick(); uv1 = 1'b0;
    @(negedge clk);
    check("bp_ur1_full", 32'(ur1), 32'd0);
    check("bp_dd1_hold", 32'(dd1), 32'hA1);
    tick(); dr1 = 1'b1;
    @(negedge clk);
    check("bp_out_a1", 32'(dd1), 32'hA1);
    check("bp_dv1_a1", 32'(dv1), 32'd1);
    tick();
    @(negedge clk);
    check("bp_out_a2", 32'(dd1), 32'hA2);
    check("bp_ur1_free", 32'(ur1), 32'd1);
    tick();
    @(negedge clk);
    check("bp_empty_dv1", 32'(dv1), 32'd0);
    check("bp_empty_dd1", 32'(dd1), 32'(FV1));

    // STALL for 3 cycles with a valid output
    tick(); dr1 = 1'b0; uv1 = 1'b1; ud1 = 8'h3C;
    tick(); uv1 = 1'b0;
    @(negedge clk); check("st_pre_dd1", 32'(dd1), 32'h3C);
    for (int i = 0; i < 3; i++) begin
      tick(); ctl1 = STALL;
      @(negedge clk);
      check("st_ur1", 32'(ur1), 32'd0);
    end
    tick(); ctl1 = CONTINUE;
    @(negedge clk);
    check("st_post_dv1", 32'(dv1), 32'd1);
    check("st_post_dd1", 32'(dd1), 32'h3C);
    check("st_count", 32'(sc1), 32'd3);

    // FLUSH with the skid full
    tick(); uv1 = 1'b1; ud1 = 8'h4D;
    @(negedge clk); check("fl_ur1_pre", 32'(ur1), 32'd1);
    tick(); uv1 = 1'b0;
    @(negedge clk); check("fl_skid_full", 32'(ur1), 32'd0);
    tick(); ctl1 = FLUSH; uv1 = 1'b1; ud1 = 8'h77;
    @(negedge clk); check("fl_ur1", 32'(ur1), 32'd0);
    tick(); ctl1 = CONTINUE; uv1 = 1'b0;
    @(negedge clk);
    check("fl_dv1", 32'(dv1), 32'd0);
    check("fl_dd1", 32'(dd1), 32'(FV1));
    check("fl_skid_empty", 32'(ur1), 32'd1);
    check("fl_count", 32'(fc1), 32'd1);
    check("fl_sc_kept", 32'(sc1), 32'd3);
    tick(); dr1 = 1'b1;
    tick();
    @(negedge clk); check("fl_nothing_left", 32'(dv1), 32'd0);

    // BUBBLE with output consumed, SKID=0
    tick(); uv0 = 1'b1; ud0 = 8'h55;
    tick(); uv0 = 1'b1; ud0 = 8'h66; ctl0 = BUBBLE;
    @(negedge clk);
    check("bub_ur0", 32'(ur0), 32'd0);
    check("bub_dd0", 32'(dd0), 32'h55);
    tick(); ctl0 = CONTINUE; uv0 = 1'b0;
    @(negedge clk);
    check("bub_dv0", 32'(dv0), 32'd0);
    check("bub_dd0_fv", 32'(dd0), 32'(FV0));

    // BUBBLE with output not consumed holds it
    tick(); dr0 = 1'b0; uv0 = 1'b1; ud0 = 8'h99;
    tick(); uv0 = 1'b0; ctl0 = BUBBLE;
    @(negedge clk); check("bubh_dd0", 32'(dd0), 32'h99);
    tick(); ctl0 = CONTINUE;
    @(negedge clk);
    check("bubh_dd0_held", 32'(dd0), 32'h99);
    check("bubh_dv0_held", 32'(dv0), 32'd1);
    tick(); dr0 = 1'b1;
    tick();
    @(negedge clk); check("bubh_drained", 32'(dv0), 32'd0);

    // BUBBLE drains the skid first, SKID=1
    tick(); dr1 = 1'b0; uv1 = 1'b1; ud1 = 8'h81;
    tick(); ud1 = 8'h82;
    tick(); uv1 = 1'b0; ctl1 = BUBBLE; dr1 = 1'b1;
    @(negedge clk);
    check("bubs_dd1_81", 32'(dd1), 32'h81);
    check("bubs_ur1", 32'(ur1), 32'd0);
    tick();
    @(negedge clk);
    check("bubs_dd1_82", 32'(dd1), 32'h82);
    check("bubs_dv1_82", 32'(dv1), 32'd1);
    tick(); ctl1 = CONTINUE;
    @(negedge clk);
    check("bubs_dv1_end", 32'(dv1), 32'd0);
    check("bubs_dd1_end", 32'(dd1), 32'(FV1));

    // Full-rate streaming, SKID=1
    for (int i = 0; i < 8; i++) begin
      tick(); uv1 = 1'b1; ud1 = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("thr_ur1", 32'(ur1), 32'd1);
      if (i > 0) check("thr_dv1", 32'(dv1), 32'd1);
    end
    tick(); uv1 = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("sb0_drained", 32'(q0.size()), 32'd0);
    check("sb1_drained", 32'(q1.size()), 32'd0);

    // Counter saturation and reset clear
    for (int i = 0; i < 20; i++) begin
      tick(); ctl1 = STALL;
    end
    tick(); ctl1 = CONTINUE;
    @(negedge clk);
    check("sat_sc1", 32'(sc1), 32'd15);
    check("sat_fc1", 32'(fc1), 32'd1);
    tick(); rst = 1'b1;
    @(negedge clk);
    check("rst2_ur1", 32'(ur1), 32'd0);
    check("rst2_ur0", 32'(ur0), 32'd0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("rst2_sc1", 32'(sc1), 32'd0);
    check("rst2_fc1", 32'(fc1), 32'd0);
    check("rst2_dv1", 32'(dv1), 32'd0);
    check("rst2_ur1_after", 32'(ur1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register that replaces the hand-written per-stage registers between fetch, decode, execute, memory and writeback. It carries an opaque payload of configurable width under a valid/ready handshake, obeys the global `pipeline_control_t` command (CONTINUE, STALL, FLUSH, BUBBLE), and optionally adds a one-entry skid buffer to cut the ready path. It also keeps saturating stall and flush counters for performance analysis.

## Interface
Parameters:
- `WIDTH`, 32: payload width in bits; the caller packs and unpacks the stage's control and data fields.
- `FLUSH_VALUE`, '0: payload presented while the stage is empty, flushed or reset. It is a NOP encoding chosen by the instantiating stage.
- `SKID`, 0: 0 gives a single register; 1 adds a one-entry skid buffer so that `up_ready_o` does not depend on `dn_ready_i`.
- `CNT_WIDTH`, 16: width of each performance counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `pipeline_control_i`  in  `pipeline_control_t`  stage command from the hazard unit.
- `up_valid_i`  in  1  upstream payload valid.
- `up_data_i`  in  WIDTH  upstream payload.
- `up_ready_o`  out  1  stage accepts upstream payload this cycle.
- `dn_valid_o`  out  1  output payload valid.
- `dn_data_o`  out  WIDTH  output payload.
- `dn_ready_i`  in  1  downstream accepts.
- `stall_count_o`  out  CNT_WIDTH  cycles spent in STALL, saturating.
- `flush_count_o`  out  CNT_WIDTH  cycles spent in FLUSH, saturating.

## Operation
- Definitions: an up transfer is `up_valid_i && up_ready_o`. A dn transfer is `dn_valid_o && dn_ready_i`.
- Command priority: `rst_i` > FLUSH > STALL > BUBBLE > CONTINUE.
- `dn_valid_o` is `out_valid_q && pipeline_control_i != STALL`, so no dn transfer can occur during STALL.
- `dn_data_o` is `out_data_q`. Whenever `out_valid_q` is 0, `out_data_q` is FLUSH_VALUE.
- FLUSH: clears the output register and the skid entry (valid 0, data FLUSH_VALUE). `up_ready_o` is 0. Any upstream payload is discarded.
- STALL: all state is held. `up_ready_o` is 0.
- BUBBLE: `up_ready_o` is 0. If the output register is empty, or a dn transfer occurs, it loads valid 0 and data FLUSH_VALUE; otherwise it holds. With SKID=1, a skid entry that is present moves to the output before any bubble is inserted; that is, BUBBLE behaves as drain-only.
- CONTINUE, SKID=0:
  - `up_ready_o` is `!out_valid_q || dn_ready_i`.
  - On a load cycle the output register loads `up_valid_i` and `up_data_i` (FLUSH_VALUE if `up_valid_i` is 0).
- CONTINUE, SKID=1:
  - `up_ready_o` is `!skid_valid_q`.
  - An up transfer while the output is full and there is no dn transfer goes to the skid entry.
  - On a dn transfer the skid entry, if valid, moves to the output; otherwise an up transfer loads the output directly.
  - With the skid full, the output is necessarily full.
- Counters: increment by 1 on each cycle with STALL (or FLUSH respectively) and saturate at all-ones. They never wrap. Only reset clears them.
- An unknown encoding of `pipeline_control_i` is treated as STALL; simulation additionally issues `$error`.

## Timing
- Latency: 1 cycle from an up transfer into an empty stage to `dn_valid_o` going high.
- Throughput: 1 payload per cycle under CONTINUE with `dn_ready_i` held high, for both SKID settings.
- Reset values: `dn_valid_o` 0, `dn_data_o` FLUSH_VALUE, both counters 0, skid empty. `up_ready_o` follows the combinational rule above after reset; it is 0 while `rst_i` is high.
- Reset or FLUSH during a pending skid entry drops that entry with no partial transfer.
- Combinational paths:
  - `up_ready_o` depends on `pipeline_control_i` in both modes, and on `dn_ready_i` only when SKID=0.
  - `dn_valid_o` depends on `pipeline_control_i`.
- Payload order is preserved; no payload is duplicated or lost except by FLUSH or reset.

## Structure
- `pipeline_pkg` owns `pipeline_control_t` (CONTINUE, STALL, FLUSH, and the new BUBBLE). All stages import it.
- Sub-module `sat_counter`, parameter WIDTH, ports `clk_i`, `rst_i`, `inc_i`, `count_o`. It is instantiated twice.
- The skid logic lives in a `generate if (SKID)` block inside `pipe_stage`.

## Test plan
- Reset and basic flow: with SKID=0 and WIDTH=8, present 0x11, 0x22, 0x33 on consecutive cycles under CONTINUE with `dn_ready_i`=1. `dn_data_o` must show 0x11, 0x22, 0x33 one cycle later with `dn_valid_o`=1.
- Backpressure, SKID=1:
  - Hold `dn_ready_i`=0 while streaming 0xA1 then 0xA2. The output holds 0xA1, the skid holds 0xA2, and `up_ready_o` goes to 0.
  - Then raise `dn_ready_i`. 0xA1 and then 0xA2 must emerge in order with no loss.
- STALL for 3 cycles with a valid output: `dn_valid_o`=0 and `up_ready_o`=0 throughout. The payload is unchanged afterwards and `stall_count_o`=3.
- FLUSH with the skid full: on the next cycle `dn_valid_o`=0, `dn_data_o`=FLUSH_VALUE, the skid is empty and `flush_count_o`=1.
- BUBBLE with the output consumed: the next output has valid 0 and data FLUSH_VALUE, and `up_ready_o`=0 during the BUBBLE cycle.
- Counter saturation: with CNT_WIDTH=4, hold STALL for 20 cycles. `stall_count_o` must stay at 15. A subsequent `rst_i` pulse must clear it to 0.
